// File: rtl/scratchpad_responder.sv
// Banked scratchpad for the systolic-array front end: serialises per-lane x/w reads and writes by bank.
// Optional feature: define SCRATCHPAD_STALL_COUNT_EN to enable the saturating conflict stall counter.
module scratchpad_responder #(
    parameter int N          = 64,
    parameter int NUM_BANKS  = 64,
    parameter int BANK_DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    sc_valid_queue,
    input  logic [N*32-1:0] sc_x_queue,
    input  logic [N*32-1:0] sc_w_queue,
    input  logic [N-1:0]    sc_valid_write,
    input  logic [N*32-1:0] sc_write_queue,
    input  logic [N*32-1:0] sc_write_data,
    output logic [N*32-1:0] sc_x_data,
    output logic [N*32-1:0] sc_w_data,
    output logic            sc_ready,
    output logic            sc_resp_valid,
    output logic [31:0]     sc_stall_cycles
);

    localparam int BB    = $clog2(NUM_BANKS);
    localparam int DB    = $clog2(BANK_DEPTH);
    localparam int AW    = BB + DB;
    localparam int WORDS = NUM_BANKS * BANK_DEPTH;

    // Handshake: a batch is taken on a rising edge where sc_ready=1 and any
    // valid bit is set; sc_resp_valid pulses once when the whole batch is done.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_RD = 2'd1,
        SERVE_WR = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [N-1:0]  r_pend_x;
    logic [N-1:0]  r_pend_w;
    logic [N-1:0]  r_pend_wr;
    logic [N-1:0]  w_gnt_x;
    logic [N-1:0]  w_gnt_w;
    logic [N-1:0]  w_gnt_wr;

    logic [AW-1:0] r_x_addr  [N];
    logic [AW-1:0] r_w_addr  [N];
    logic [AW-1:0] r_wr_addr [N];
    logic [31:0]   r_wr_data [N];
    logic [31:0]   r_x_data  [N];
    logic [31:0]   r_w_data  [N];

    logic [31:0]   r_mem [WORDS];

    logic          w_accept;
    logic          w_any_rd;
    logic          w_unused_addr_bits;

    assign w_any_rd           = |sc_valid_queue;
    assign w_accept           = (r_state == IDLE) && (w_any_rd || (|sc_valid_write));
    assign w_unused_addr_bits = ^{sc_x_queue, sc_w_queue, sc_write_queue};

    assign sc_ready      = (r_state == IDLE);
    assign sc_resp_valid = (r_state == DONE);

    for (genvar g = 0; g < N; g++) begin : g_out
        assign sc_x_data[g*32 +: 32] = r_x_data[g];
        assign sc_w_data[g*32 +: 32] = r_w_data[g];
    end

    // Per bank, the lowest-indexed pending lane wins; a lane loses if any
    // lower pending lane of the same kind targets the same bank.
    always_comb begin
        w_gnt_x  = '0;
        w_gnt_w  = '0;
        w_gnt_wr = '0;
        for (int i = 0; i < N; i++) begin
            w_gnt_x[i]  = r_pend_x[i]  && (r_state == SERVE_RD);
            w_gnt_w[i]  = r_pend_w[i]  && (r_state == SERVE_RD);
            w_gnt_wr[i] = r_pend_wr[i] && (r_state == SERVE_WR);
            for (int j = 0; j < N; j++) begin
                if (j < i) begin
                    if (r_pend_x[j] && (r_x_addr[j][BB-1:0] == r_x_addr[i][BB-1:0]))
                        w_gnt_x[i] = 1'b0;
                    if (r_pend_w[j] && (r_w_addr[j][BB-1:0] == r_w_addr[i][BB-1:0]))
                        w_gnt_w[i] = 1'b0;
                    if (r_pend_wr[j] && (r_wr_addr[j][BB-1:0] == r_wr_addr[i][BB-1:0]))
                        w_gnt_wr[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_next_state = w_any_rd ? SERVE_RD : SERVE_WR;
            end
            SERVE_RD: begin
                if (((r_pend_x & ~w_gnt_x) == '0) && ((r_pend_w & ~w_gnt_w) == '0))
                    w_next_state = (r_pend_wr != '0) ? SERVE_WR : DONE;
            end
            SERVE_WR: begin
                if ((r_pend_wr & ~w_gnt_wr) == '0)
                    w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_x  <= '0;
            r_pend_w  <= '0;
            r_pend_wr <= '0;
            for (int i = 0; i < N; i++) begin
                r_x_addr[i]  <= '0;
                r_w_addr[i]  <= '0;
                r_wr_addr[i] <= '0;
                r_wr_data[i] <= '0;
                r_x_data[i]  <= '0;
                r_w_data[i]  <= '0;
            end
        end else begin
            if (w_accept) begin
                r_pend_x  <= sc_valid_queue;
                r_pend_w  <= sc_valid_queue;
                r_pend_wr <= sc_valid_write;
                for (int i = 0; i < N; i++) begin
                    r_x_addr[i]  <= sc_x_queue[i*32 +: AW];
                    r_w_addr[i]  <= sc_w_queue[i*32 +: AW];
                    r_wr_addr[i] <= sc_write_queue[i*32 +: AW];
                    r_wr_data[i] <= sc_write_data[i*32 +: 32];
                    r_x_data[i]  <= '0;
                    r_w_data[i]  <= '0;
                end
            end
            if (r_state == SERVE_RD) begin
                r_pend_x <= r_pend_x & ~w_gnt_x;
                r_pend_w <= r_pend_w & ~w_gnt_w;
                for (int i = 0; i < N; i++) begin
                    if (w_gnt_x[i]) r_x_data[i] <= r_mem[r_x_addr[i]];
                    if (w_gnt_w[i]) r_w_data[i] <= r_mem[r_w_addr[i]];
                end
            end
            if (r_state == SERVE_WR)
                r_pend_wr <= r_pend_wr & ~w_gnt_wr;
        end
    end

    // Granted writers in one cycle always hit distinct banks, so no two
    // writes in the same cycle can target the same word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (w_gnt_wr[i])
                r_mem[r_wr_addr[i]] <= r_wr_data[i];
        end
    end

`ifdef SCRATCHPAD_STALL_COUNT_EN
    logic [31:0] r_stall;
    logic        r_first;

    // r_first marks the opening cycle of a serve phase, which is not a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
            r_first <= 1'b0;
        end else begin
            r_first <= (w_next_state != r_state);
            if (((r_state == SERVE_RD) || (r_state == SERVE_WR)) && !r_first
                && (r_stall != 32'hFFFF_FFFF))
                r_stall <= r_stall + 32'd1;
        end
    end

    assign sc_stall_cycles = r_stall;
`else
    assign sc_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_scratchpad_responder.sv
// Directed bench for scratchpad_responder: driver issues batches, monitor checks
// each response against a queue of hand-computed expectations.
module tb_scratchpad_responder;

    localparam int N          = 4;
    localparam int NUM_BANKS  = 4;
    localparam int BANK_DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    sc_valid_queue;
    logic [N*32-1:0] sc_x_queue;
    logic [N*32-1:0] sc_w_queue;
    logic [N-1:0]    sc_valid_write;
    logic [N*32-1:0] sc_write_queue;
    logic [N*32-1:0] sc_write_data;
    logic [N*32-1:0] sc_x_data;
    logic [N*32-1:0] sc_w_data;
    logic            sc_ready;
    logic            sc_resp_valid;
    logic [31:0]     sc_stall_cycles;

    typedef struct packed {
        logic [127:0] x;
        logic [127:0] w;
        logic [31:0]  stall;
        logic [31:0]  lat;
        logic [31:0]  t_acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_stall = 0;

    scratchpad_responder #(
        .N(N), .NUM_BANKS(NUM_BANKS), .BANK_DEPTH(BANK_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .sc_valid_queue(sc_valid_queue), .sc_x_queue(sc_x_queue), .sc_w_queue(sc_w_queue),
        .sc_valid_write(sc_valid_write), .sc_write_queue(sc_write_queue),
        .sc_write_data(sc_write_data), .sc_x_data(sc_x_data), .sc_w_data(sc_w_data),
        .sc_ready(sc_ready), .sc_resp_valid(sc_resp_valid), .sc_stall_cycles(sc_stall_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pops one expectation.
    always @(negedge clk) begin
        if (!rst && sc_resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("x_data", sc_x_data, mon_e.x);
                check("w_data", sc_w_data, mon_e.w);
                check("stall_cycles", {96'h0, sc_stall_cycles}, {96'h0, mon_e.stall});
                check("latency", 128'(cyc - int'(mon_e.t_acc) + 1), {96'h0, mon_e.lat});
                check("ready_low_in_done", {127'h0, sc_ready}, 128'h0);
            end
        end
    end

    task automatic issue(input logic [3:0] vq, input logic [127:0] xq, input logic [127:0] wq,
                         input logic [3:0] vw, input logic [127:0] wrq, input logic [127:0] wdq,
                         input logic [127:0] ex, input logic [127:0] ew,
                         input int stall_inc, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        sc_valid_queue = vq;
        sc_x_queue     = xq;
        sc_w_queue     = wq;
        sc_valid_write = vw;
        sc_write_queue = wrq;
        sc_write_data  = wdq;
        @(posedge clk);
        #1;
        if (push) begin
            exp_stall += stall_inc;
            e.x     = ex;
            e.w     = ew;
`ifdef SCRATCHPAD_STALL_COUNT_EN
            e.stall = 32'(exp_stall);
`else
            e.stall = 32'h0;
`endif
            e.lat   = 32'(lat);
            e.t_acc = 32'(cyc);
            exp_q.push_back(e);
        end
        // Scramble everything but the valids: the batch must already be latched.
        sc_valid_queue = '0;
        sc_valid_write = '0;
        sc_x_queue     = {$urandom(), $urandom(), $urandom(), $urandom()};
        sc_w_queue     = {$urandom(), $urandom(), $urandom(), $urandom()};
        sc_write_queue = {$urandom(), $urandom(), $urandom(), $urandom()};
        sc_write_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_idle();
        bit done_ok;
        done_ok = 1'b0;
        for (int k = 0; k < 60 && !done_ok; k++) begin
            @(negedge clk);
            if (sc_ready && exp_q.size() == 0) done_ok = 1'b1;
        end
        n_checks++;
        if (!done_ok) begin
            n_fail++;
            $display("FAIL wait_idle: got timeout with %0d responses pending, expected idle", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {127'h0, sc_ready}, 128'h1);
        check({tag, "_resp_valid"}, {127'h0, sc_resp_valid}, 128'h0);
        check({tag, "_x_data"}, sc_x_data, 128'h0);
        check({tag, "_w_data"}, sc_w_data, 128'h0);
        check({tag, "_stall"}, {96'h0, sc_stall_cycles}, 128'h0);
    endtask

    initial begin
        sc_valid_queue = '0;
        sc_valid_write = '0;
        sc_x_queue     = '0;
        sc_w_queue     = '0;
        sc_write_queue = '0;
        sc_write_data  = '0;

        #3 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Write-only: addr 0..3 <= A0..A3
        issue(4'b0000, 128'h0, 128'h0,
              4'b1111, {32'h3, 32'h2, 32'h1, 32'h0}, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
              128'h0, 128'h0, 0, 2, 1'b1);
        wait_idle();

        // Read-only: x=0..3, w=3..0
        issue(4'b1111, {32'h3, 32'h2, 32'h1, 32'h0}, {32'h0, 32'h1, 32'h2, 32'h3},
              4'b0000, 128'h0, 128'h0,
              {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {32'hA0, 32'hA1, 32'hA2, 32'hA3}, 0, 2, 1'b1);
        wait_idle();

        // Write conflict: three writes to bank 0, one to bank 1
        issue(4'b0000, 128'h0, 128'h0,
              4'b1111, {32'h5, 32'hC, 32'h8, 32'h4}, {32'h11, 32'hBC, 32'hB8, 32'hB4},
              128'h0, 128'h0, 2, 4, 1'b1);
        wait_idle();

        // Read conflict: all x lanes in bank 0
        issue(4'b1111, {32'hC, 32'h8, 32'h4, 32'h0}, {32'h0, 32'h3, 32'h2, 32'h1},
              4'b0000, 128'h0, 128'h0,
              {32'hBC, 32'hB8, 32'hB4, 32'hA0}, {32'hA0, 32'hA3, 32'hA2, 32'hA1}, 3, 5, 1'b1);
        wait_idle();

        // Read-before-write and same-address writes (lane 2 must win)
        issue(4'b0001, {32'h0, 32'h0, 32'h0, 32'h5}, 128'h0,
              4'b0110, {32'h0, 32'h5, 32'h5, 32'h0}, {32'h0, 32'h33, 32'h22, 32'h0},
              {32'h0, 32'h0, 32'h0, 32'h11}, {32'h0, 32'h0, 32'h0, 32'hA0}, 1, 4, 1'b1);
        wait_idle();

        issue(4'b0001, {32'h0, 32'h0, 32'h0, 32'h5}, {32'h0, 32'h0, 32'h0, 32'h5},
              4'b0000, 128'h0, 128'h0,
              {32'h0, 32'h0, 32'h0, 32'h33}, {32'h0, 32'h0, 32'h0, 32'h33}, 0, 2, 1'b1);
        wait_idle();

        // Mid-batch reset during a 4-cycle read conflict: no response may appear
        issue(4'b1111, {32'hD, 32'h9, 32'h5, 32'h1}, {32'h3, 32'h2, 32'h1, 32'h0},
              4'b0000, 128'h0, 128'h0, 128'h0, 128'h0, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid_batch");
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("ready_after_abort", {127'h0, sc_ready}, 128'h1);

        // Memory intact after reset; 0x40 aliases 0
        issue(4'b1111, {32'h3, 32'h2, 32'h1, 32'h40}, {32'h3, 32'h2, 32'h40, 32'h5},
              4'b0000, 128'h0, 128'h0,
              {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {32'hA3, 32'hA2, 32'hA0, 32'h33}, 0, 2, 1'b1);
        wait_idle();

        // Conflict-free read+write, then read back through an aliased address
        issue(4'b0001, {32'h0, 32'h0, 32'h0, 32'h2}, {32'h0, 32'h0, 32'h0, 32'h3},
              4'b0010, {32'h0, 32'h0, 32'h3F, 32'h0}, {32'h0, 32'h0, 32'h77, 32'h0},
              {32'h0, 32'h0, 32'h0, 32'hA2}, {32'h0, 32'h0, 32'h0, 32'hA3}, 0, 3, 1'b1);
        wait_idle();

        issue(4'b0001, {32'h0, 32'h0, 32'h0, 32'h3F}, {32'h0, 32'h0, 32'h0, 32'h7F},
              4'b0000, 128'h0, 128'h0,
              {32'h0, 32'h0, 32'h0, 32'h77}, {32'h0, 32'h0, 32'h0, 32'h77}, 0, 2, 1'b1);
        wait_idle();

        check("queue_drained", 128'(exp_q.size()), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
